serial_tx_arbiter: RTL and testbench
====================================

# serial_tx_arbiter

Shares the single byte serializer among the three character sources (keyboard, wordboard, tweetboard) instead of a static mode mux. Each source gets a one-byte holding slot. A round-robin scheduler grants pending slots to the serializer and runs a start/busy handshake with a bounded acknowledge timeout. Sticky overrun and timeout flags report lost bytes. The block sits between the source modules and the serializer, in place of the data/start multiplexer.

## Interface
- `W`, 8: data byte width.
- `ACK_TIMEOUT`, 16: cycles allowed after `tx_start` for `tx_busy` to rise; range 1..255.
- `GAP_CYCLES`, 4: idle cycles inserted after each byte before the next grant; 0 is legal.
- `sysclk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `src_data0`, `src_data1`, `src_data2` in W: source byte, sampled when the matching start is high.
- `src_start` in 3: one-cycle write request per source; bit i belongs to source i.
- `src_en` in 3: source enable; a start while the source is disabled is ignored.
- `src_full` out 3: slot i holds an unsent byte.
- `tx_data` out W: byte presented to the serializer.
- `tx_start` out 1: one-cycle start pulse to the serializer.
- `tx_busy` in 1: serializer is shifting.
- `grant` out 3: one-hot owner of the current transfer; 0 when idle.
- `overrun` out 3: sticky; source i wrote while its slot was full.
- `timeout_err` out 1: sticky; the serializer never acknowledged a start.
- `clr_err` in 1: one-cycle pulse; clears `overrun` and `timeout_err`.

## Operation
- Slot i loads when `src_start[i] & src_en[i]`. `src_full[i]` is set on the next edge.
  - If the slot is full and not being drained this cycle: the new byte is dropped, the old byte is kept, and `overrun[i]` is set.
  - If the slot is being drained in the same cycle: the new byte is accepted, `src_full[i]` stays 1, no overrun.
- Clearing a source's `src_en` does not flush its slot; a pending byte still gets sent.
- FSM states:
  - **IDLE**: if any slot is full, pick the first full slot in round-robin order starting at `ptr`.
    - Copy that slot's byte into `tx_data`, clear the slot, set `grant`.
    - Set `ptr` to (winner+1) mod 3, then go to ISSUE.
  - **ISSUE**: `tx_start`=1 for exactly this cycle. Go to WAIT_ACK.
  - **WAIT_ACK**: the counter increments each cycle.
    - `tx_busy`=1: go to SEND.
    - Counter reaches `ACK_TIMEOUT`: set `timeout_err`, go to GAP. The byte is discarded, not retried.
  - **SEND**: wait for `tx_busy`=0, then go to GAP.
  - **GAP**: stay `GAP_CYCLES` cycles, then clear `grant` and go to IDLE. With `GAP_CYCLES`=0, go directly to IDLE.
- `tx_data` holds its value from the grant until the next grant.
- `clr_err` and a new flag event in the same cycle: the set wins.
- Reset values: FSM=IDLE, `ptr`=0, `tx_data`=0, `tx_start`=0, `grant`=0, `src_full`=0, `overrun`=0, `timeout_err`=0, counters=0.
- Reset asserted mid-transfer aborts immediately: pending slots are lost and `tx_start` drops asynchronously.

## Timing
- Start sampled at edge k → `src_full` high after edge k → grant and ISSUE after edge k+1 (block idle) → `tx_start` high for the cycle between edges k+1 and k+2.
- Back-to-back: the next `tx_start` comes `GAP_CYCLES`+2 cycles after the cycle in which `tx_busy` is sampled low.
- The counter equal to `ACK_TIMEOUT` is detected `ACK_TIMEOUT` cycles after leaving ISSUE; `timeout_err` is visible the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `tx_arb_pkg`: FSM state encoding (IDLE, ISSUE, WAIT_ACK, SEND, GAP), `N_SRC`=3, and a round-robin pick function taking (full vector, ptr).
- Sub-module `tx_req_slot`: one holding register plus full and overrun logic, instantiated three times.
- Top level: FSM, pointer, timeout counter, gap counter, output registers.

## Test plan
- Single byte: source 1 writes 0xA5 with `tx_busy` pulsed high 10 cycles → `tx_start` one cycle, 2 cycles after the write; `tx_data`=0xA5; `grant`=3'b010; `src_full[1]` clears at the grant.
- Fairness: all three write in the same cycle (0x11, 0x22, 0x33), `ptr`=0 → order 0x11, 0x22, 0x33. Repeat with `ptr`=2 → order 0x33, 0x11, 0x22.
- Overrun: source 0 writes 0x40, then 0x41 while the serializer is busy on another source → 0x40 is sent, 0x41 is dropped, `overrun`=3'b001. `clr_err` returns it to 0.
- Drain-and-load: source 2 writes 0x55 in the same cycle its slot is granted → no overrun; 0x55 is sent next.
- Timeout: `ACK_TIMEOUT`=16, `tx_busy` held low → `timeout_err`=1 the cycle after the counter reaches 16, block returns to IDLE, the next pending byte is sent normally.
- Reset in SEND: assert `reset` low → `grant`=0, `tx_start`=0, `src_full`=0 immediately. After release, a new write sends normally.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared definitions for the serial TX arbiter
//   N_SRC   - number of character sources sharing the serializer
//   state_e - scheduler FSM state encoding
//   rr_pick - first set bit of a full vector, searching round-robin from ptr
package tx_arb_pkg;
   localparam int N_SRC = 3;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, SEND, GAP} state_e;
   function automatic logic [1:0] rr_pick(input logic [N_SRC-1:0] full, input logic [1:0] ptr);
      logic [1:0] win;
      logic [1:0] j;
      win = ptr;
      // Walk backwards so the candidate closest to ptr is written last and wins.
      for (int k = N_SRC - 1; k >= 0; k--) begin
         j = 2'((int'(ptr) + k) % N_SRC);
         if (full[j]) win = j;
      end
      return win;
   endfunction
endpackage

// File: rtl/tx_req_slot.sv
// tx_req_slot: one-byte holding slot with full flag and sticky overrun
//   clk_i/rst_ni - clock, async active-low reset
//   wr_i/data_i  - write request and byte
//   drain_i      - slot is granted this cycle
//   clr_i        - clears the sticky overrun
//   full_o/data_o/overrun_o - slot state
module tx_req_slot #(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         wr_i,
   input  logic         drain_i,
   input  logic         clr_i,
   input  logic [W-1:0] data_i,
   output logic         full_o,
   output logic         overrun_o,
   output logic [W-1:0] data_o
);
   logic         full_q, full_d, ovr_q, ovr_d, accept;
   logic [W-1:0] data_q, data_d;
   always_comb begin
      // A write lands if the slot is empty or being emptied in the same cycle.
      accept = wr_i & (~full_q | drain_i);
      full_d = accept | (full_q & ~drain_i);
      data_d = accept ? data_i : data_q;
      ovr_d  = (wr_i & full_q & ~drain_i) | (ovr_q & ~clr_i);
   end
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         full_q <= 1'b0;
         ovr_q  <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         ovr_q  <= ovr_d;
         data_q <= data_d;
      end
   end
   assign full_o    = full_q;
   assign overrun_o = ovr_q;
   assign data_o    = data_q;
endmodule

// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin sharing of one byte serializer among three sources
//   sysclk/reset            - clock, async active-low reset
//   src_data0..2/src_start/src_en - source bytes, write pulses, enables
//   src_full/overrun        - per-slot pending and sticky lost-byte flags
//   tx_data/tx_start/tx_busy - serializer handshake
//   grant                   - one-hot owner of the current transfer
//   timeout_err/clr_err     - sticky missing-ack flag and error clear
module serial_tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int W           = 8,
   parameter int ACK_TIMEOUT = 16,
   parameter int GAP_CYCLES  = 4
) (
   input  logic             sysclk,
   input  logic             reset,
   input  logic [W-1:0]     src_data0,
   input  logic [W-1:0]     src_data1,
   input  logic [W-1:0]     src_data2,
   input  logic [N_SRC-1:0] src_start,
   input  logic [N_SRC-1:0] src_en,
   output logic [N_SRC-1:0] src_full,
   output logic [W-1:0]     tx_data,
   output logic             tx_start,
   input  logic             tx_busy,
   output logic [N_SRC-1:0] grant,
   output logic [N_SRC-1:0] overrun,
   output logic             timeout_err,
   input  logic             clr_err
);
   localparam state_e AFTER_TX = (GAP_CYCLES == 0) ? IDLE : GAP;
   logic [W-1:0]     src_bytes [N_SRC];
   logic [W-1:0]     slot_data [N_SRC];
   logic [N_SRC-1:0] drain;
   logic [1:0]       win;
   state_e           state_q;
   logic [1:0]       ptr_q;
   logic [7:0]       ack_cnt_q, gap_cnt_q;
   logic [W-1:0]     tx_data_q;
   logic             tx_start_q, timeout_q;
   logic [N_SRC-1:0] grant_q;
   assign src_bytes[0] = src_data0;
   assign src_bytes[1] = src_data1;
   assign src_bytes[2] = src_data2;
   assign win   = rr_pick(src_full, ptr_q);
   assign drain = (state_q == IDLE && |src_full) ? 3'b001 << win : 3'b000;
   for (genvar i = 0; i < N_SRC; i++) begin : g_slot
      tx_req_slot #(.W(W)) u_slot (
         .clk_i    (sysclk),
         .rst_ni   (reset),
         .wr_i     (src_start[i] & src_en[i]),
         .drain_i  (drain[i]),
         .clr_i    (clr_err),
         .data_i   (src_bytes[i]),
         .full_o   (src_full[i]),
         .overrun_o(overrun[i]),
         .data_o   (slot_data[i])
      );
   end
   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         ptr_q      <= 2'd0;
         ack_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         grant_q    <= '0;
         timeout_q  <= 1'b0;
      end else begin
         tx_start_q <= 1'b0;
         // A timeout set later in this block overrides the clear.
         if (clr_err) timeout_q <= 1'b0;
         case (state_q)
            IDLE: if (|src_full) begin
               tx_data_q  <= slot_data[win];
               grant_q    <= 3'b001 << win;
               ptr_q      <= (win == 2'd2) ? 2'd0 : win + 2'd1;
               tx_start_q <= 1'b1;
               state_q    <= ISSUE;
            end
            ISSUE: begin
               ack_cnt_q <= '0;
               state_q   <= WAIT_ACK;
            end
            WAIT_ACK: if (tx_busy) state_q <= SEND;
            else if (ack_cnt_q == 8'(ACK_TIMEOUT)) begin
               timeout_q <= 1'b1;
               gap_cnt_q <= '0;
               grant_q   <= (AFTER_TX == IDLE) ? '0 : grant_q;
               state_q   <= AFTER_TX;
            end else ack_cnt_q <= ack_cnt_q + 8'd1;
            SEND: if (!tx_busy) begin
               gap_cnt_q <= '0;
               grant_q   <= (AFTER_TX == IDLE) ? '0 : grant_q;
               state_q   <= AFTER_TX;
            end
            GAP: if (gap_cnt_q == 8'(GAP_CYCLES - 1)) begin
               grant_q <= '0;
               state_q <= IDLE;
            end else gap_cnt_q <= gap_cnt_q + 8'd1;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign tx_data     = tx_data_q;
   assign tx_start    = tx_start_q;
   assign grant       = grant_q;
   assign timeout_err = timeout_q;
endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter: scoreboard bench with a transaction-level round-robin model
module tb_serial_tx_arbiter;
   logic       sysclk = 1'b0, reset = 1'b0;
   logic [7:0] src_data0 = '0, src_data1 = '0, src_data2 = '0;
   logic [2:0] src_start = '0, src_en = '0;
   logic [2:0] src_full, grant, overrun;
   logic [7:0] tx_data;
   logic       tx_start, timeout_err;
   logic       tx_busy = 1'b0, clr_err = 1'b0;

   serial_tx_arbiter dut (
      .sysclk(sysclk), .reset(reset),
      .src_data0(src_data0), .src_data1(src_data1), .src_data2(src_data2),
      .src_start(src_start), .src_en(src_en), .src_full(src_full),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .grant(grant), .overrun(overrun), .timeout_err(timeout_err), .clr_err(clr_err)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {logic [2:0] g; logic [7:0] d;} exp_t;
   exp_t exp_q[$];
   int   total = 0, passed = 0;
   int   mptr = 0;
   bit   nack = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference: written bytes leave in round-robin order from the model pointer.
   task automatic model_write(input logic [2:0] eff, input logic [7:0] d0, d1, d2);
      logic [7:0] d [3];
      exp_t e;
      int first;
      d[0] = d0; d[1] = d1; d[2] = d2;
      first = mptr;
      for (int k = 0; k < 3; k++) begin
         int j;
         j = (first + k) % 3;
         if (eff[j]) begin
            e.g = 3'(1 << j);
            e.d = d[j];
            exp_q.push_back(e);
            mptr = (j + 1) % 3;
         end
      end
   endtask

   // Monitor: every start pulse must match the head of the scoreboard.
   initial begin
      logic prev;
      exp_t e;
      prev = 1'b0;
      forever begin
         @(negedge sysclk);
         if (tx_start) begin
            chk("start_single_cycle", {31'd0, prev}, 0);
            chk("sb_has_entry", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("sb_grant", grant, e.g);
               chk("sb_data", tx_data, e.d);
            end
         end
         prev = tx_start;
      end
   end

   // Serializer model: acknowledges each start after a short random delay.
   initial forever begin
      @(negedge sysclk);
      if (tx_start && !nack) begin
         repeat ($urandom_range(0, 3)) @(negedge sysclk);
         tx_busy = 1'b1;
         repeat ($urandom_range(2, 8)) @(negedge sysclk);
         tx_busy = 1'b0;
      end
   end

   task automatic wr(input logic [2:0] st, input logic [2:0] en, input logic [7:0] d0, d1, d2);
      src_start = st; src_en = en;
      src_data0 = d0; src_data1 = d1; src_data2 = d2;
      @(negedge sysclk);
      src_start = '0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!(grant == 0 && src_full == 0 && exp_q.size() == 0 && !tx_busy) && n < 400) begin
         @(negedge sysclk);
         n++;
      end
      chk("idle_reached", n < 400, 1);
      repeat (2) @(negedge sysclk);
   endtask

   task automatic wait_start();
      int n;
      n = 0;
      while (!tx_start && n < 50) begin
         @(negedge sysclk);
         n++;
      end
      chk("start_seen", tx_start, 1);
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      @(negedge sysclk);
      clr_err = 1'b0;
      @(negedge sysclk);
   endtask

   initial begin
      logic [7:0] b0, b1, b2;
      logic [2:0] st, en;
      repeat (3) @(negedge sysclk);
      reset = 1'b1;
      @(negedge sysclk);
      chk("rst_grant", grant, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_tx_data", tx_data, 0);
      chk("rst_src_full", src_full, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout_err, 0);

      // Fairness from ptr=0: 11, 22, 33.
      wr(3'b111, 3'b111, 8'h11, 8'h22, 8'h33);
      model_write(3'b111, 8'h11, 8'h22, 8'h33);
      chk("fair0_full", src_full, 3'b111);
      wait_idle();

      // Single byte with start timing.
      wr(3'b010, 3'b111, 8'h00, 8'hA5, 8'h00);
      model_write(3'b010, 8'h00, 8'hA5, 8'h00);
      chk("single_full", src_full, 3'b010);
      chk("single_no_start_yet", tx_start, 0);
      @(negedge sysclk);
      chk("single_start", tx_start, 1);
      chk("single_grant", grant, 3'b010);
      chk("single_data", tx_data, 8'hA5);
      chk("single_full_clr", src_full, 0);
      wait_idle();

      // Fairness from ptr=2: 33, 11, 22.
      wr(3'b111, 3'b111, 8'h11, 8'h22, 8'h33);
      model_write(3'b111, 8'h11, 8'h22, 8'h33);
      wait_idle();

      // Overrun: source 0 rewritten while source 2 owns the serializer.
      wr(3'b101, 3'b111, 8'h40, 8'h00, 8'h77);
      model_write(3'b101, 8'h40, 8'h00, 8'h77);
      wait_start();
      wr(3'b001, 3'b111, 8'h41, 8'h00, 8'h00);
      chk("ovr_set", overrun, 3'b001);
      chk("ovr_slot_kept", src_full, 3'b001);
      wait_idle();
      chk("ovr_sticky", overrun, 3'b001);
      pulse_clr();
      chk("ovr_cleared", overrun, 0);

      // Drain-and-load on source 2.
      b1 = 8'($urandom);
      wr(3'b100, 3'b111, 8'h00, 8'h00, b1);
      model_write(3'b100, 8'h00, 8'h00, b1);
      wr(3'b100, 3'b111, 8'h00, 8'h00, 8'h55);
      model_write(3'b100, 8'h00, 8'h00, 8'h55);
      chk("dl_no_overrun", overrun, 0);
      chk("dl_full", src_full, 3'b100);
      wait_idle();
      chk("dl_no_overrun_end", overrun, 0);

      // Timeout: serializer never acknowledges.
      nack = 1'b1;
      wr(3'b001, 3'b111, 8'h9C, 8'h00, 8'h00);
      model_write(3'b001, 8'h9C, 8'h00, 8'h00);
      wait_start();
      repeat (17) @(negedge sysclk);
      chk("to_not_yet", timeout_err, 0);
      @(negedge sysclk);
      chk("to_set", timeout_err, 1);
      nack = 1'b0;
      wait_idle();
      wr(3'b010, 3'b111, 8'h00, 8'h3E, 8'h00);
      model_write(3'b010, 8'h00, 8'h3E, 8'h00);
      wait_idle();
      chk("to_sticky", timeout_err, 1);
      pulse_clr();
      chk("to_cleared", timeout_err, 0);

      // Reset during SEND with another byte pending.
      wr(3'b001, 3'b111, 8'hC3, 8'h00, 8'h00);
      model_write(3'b001, 8'hC3, 8'h00, 8'h00);
      begin
         int n;
         n = 0;
         while (!tx_busy && n < 50) begin
            @(negedge sysclk);
            n++;
         end
         chk("rs_busy_seen", tx_busy, 1);
      end
      wr(3'b010, 3'b111, 8'h00, 8'hD4, 8'h00);
      chk("rs_pending", src_full, 3'b010);
      #2 reset = 1'b0;
      #1;
      chk("rs_grant", grant, 0);
      chk("rs_tx_start", tx_start, 0);
      chk("rs_src_full", src_full, 0);
      exp_q.delete();
      mptr = 0;
      @(negedge sysclk);
      reset = 1'b1;
      wait_idle();
      wr(3'b100, 3'b111, 8'h00, 8'h00, 8'hE7);
      model_write(3'b100, 8'h00, 8'h00, 8'hE7);
      wait_idle();

      // Randomized batches, including disabled-source writes.
      for (int it = 0; it < 25; it++) begin
         st = 3'($urandom_range(0, 7));
         en = 3'($urandom_range(0, 7));
         b0 = 8'($urandom); b1 = 8'($urandom); b2 = 8'($urandom);
         wr(st, en, b0, b1, b2);
         model_write(st & en, b0, b1, b2);
         chk("rand_full", src_full, st & en);
         wait_idle();
      end
      chk("rand_no_overrun", overrun, 0);
      chk("sb_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
